// File: rtl/dual2_seq_ctrl_if.sv
// ============================================================================
// Module   : dual2_seq_ctrl_if
// Brief    : Start/busy/done handshake and result bundle for dual2_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dual2_seq_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 4
);
  logic                  start;
  logic [2*DIGITS-1:0]   a;
  logic [2*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic                  neq;
  logic                  a_gt_b;
  logic                  a_lt_b;
  logic [IDXW-1:0]       diff_idx;

  modport master (
    output start, a, b,
    input  busy, done, neq, a_gt_b, a_lt_b, diff_idx
  );

  modport slave (
    input  start, a, b,
    output busy, done, neq, a_gt_b, a_lt_b, diff_idx
  );
endinterface

`default_nettype wire

// File: rtl/dual2_seq_ctrl.sv
// ============================================================================
// Module   : dual2_seq_ctrl
// Brief    : MSD-first digit-serial compare of two 2-bit-digit operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual2_seq_ctrl #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 4
) (
  input  wire logic       CLOCK_50,
  input  wire logic [3:0] KEY,
  dual2_seq_ctrl_if.slave bus
);

  localparam logic [IDXW-1:0] C_MSD = IDXW'(DIGITS - 1);
  localparam logic [IDXW-1:0] C_ONE = IDXW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_nx_state;
  logic [2*DIGITS-1:0] r_a, w_nx_a;
  logic [2*DIGITS-1:0] r_b, w_nx_b;
  logic [IDXW-1:0]     r_idx, w_nx_idx;
  logic                r_busy, w_nx_busy;
  logic                r_done, w_nx_done;
  logic                r_neq, w_nx_neq;
  logic                r_gt, w_nx_gt;
  logic                r_lt, w_nx_lt;
  logic [IDXW-1:0]     r_diff_idx, w_nx_diff_idx;
  logic [1:0]          w_ad, w_bd;
  logic                w_differ;

  wire  w_key_unused = ^KEY[3:1];

  // Current digit pair selected by the scan index.
  always_comb begin
    w_ad = 2'b00;
    w_bd = 2'b00;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_ad = r_a[2*i +: 2];
        w_bd = r_b[2*i +: 2];
      end
    end
  end

  assign w_differ = (w_ad[1] ^ w_bd[1]) | (w_ad[0] ^ w_bd[0]);

  always_comb begin
    w_nx_state    = r_state;
    w_nx_a        = r_a;
    w_nx_b        = r_b;
    w_nx_idx      = r_idx;
    w_nx_neq      = r_neq;
    w_nx_gt       = r_gt;
    w_nx_lt       = r_lt;
    w_nx_diff_idx = r_diff_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nx_a        = bus.a;
          w_nx_b        = bus.b;
          w_nx_idx      = C_MSD;
          w_nx_neq      = 1'b0;
          w_nx_gt       = 1'b0;
          w_nx_lt       = 1'b0;
          w_nx_diff_idx = '0;
          w_nx_state    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_differ) begin
          w_nx_neq      = 1'b1;
          w_nx_gt       = (w_ad > w_bd);
          w_nx_lt       = (w_ad < w_bd);
          w_nx_diff_idx = r_idx;
          w_nx_state    = S_DONE;
        end else if (r_idx == '0) begin
          w_nx_neq      = 1'b0;
          w_nx_gt       = 1'b0;
          w_nx_lt       = 1'b0;
          w_nx_diff_idx = '0;
          w_nx_state    = S_DONE;
        end else begin
          w_nx_idx      = r_idx - C_ONE;
        end
      end
      S_DONE:  w_nx_state = S_IDLE;
      default: w_nx_state = S_IDLE;
    endcase
    // Status flags are registered copies of the state being entered.
    w_nx_busy = (w_nx_state != S_IDLE);
    w_nx_done = (w_nx_state == S_DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_neq      <= 1'b0;
      r_gt       <= 1'b0;
      r_lt       <= 1'b0;
      r_diff_idx <= '0;
    end else begin
      r_state    <= w_nx_state;
      r_a        <= w_nx_a;
      r_b        <= w_nx_b;
      r_idx      <= w_nx_idx;
      r_busy     <= w_nx_busy;
      r_done     <= w_nx_done;
      r_neq      <= w_nx_neq;
      r_gt       <= w_nx_gt;
      r_lt       <= w_nx_lt;
      r_diff_idx <= w_nx_diff_idx;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.neq      = r_neq;
  assign bus.a_gt_b   = r_gt;
  assign bus.a_lt_b   = r_lt;
  assign bus.diff_idx = r_diff_idx;

endmodule

`default_nettype wire

// File: tb/tb_dual2_seq_ctrl.sv
// ============================================================================
// Module   : tb_dual2_seq_ctrl
// Brief    : Self-checking bench for dual2_seq_ctrl against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual2_seq_ctrl;

  localparam int DIGITS = 4;
  localparam int IDXW   = 4;
  localparam int W      = 2 * DIGITS;

  logic       clk;
  logic [3:0] key;
  int         n_cmp;
  int         n_bad;
  logic       chk_en;
  int         n_done;

  dual2_seq_ctrl_if #(.DIGITS(DIGITS), .IDXW(IDXW)) bus ();

  dual2_seq_ctrl #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cycle 1 follows the accepting edge; done lands on cycle m_lat.
  int   m_cyc = 0;
  int   m_lat = 0;
  logic m_neq = 1'b0, m_gt = 1'b0, m_lt = 1'b0;
  int   m_idx = 0;
  logic p_neq, p_gt, p_lt;
  int   p_idx;

  task automatic predict(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] x;
    int hb;
    x  = av ^ bv;
    hb = -1;
    for (int i = 0; i < W; i++) if (x[i]) hb = i;
    if (hb < 0) begin
      p_neq = 0; p_gt = 0; p_lt = 0; p_idx = 0;
      m_lat = DIGITS + 1;
    end else begin
      p_neq = 1; p_gt = (av > bv); p_lt = (av < bv); p_idx = hb / 2;
      m_lat = (DIGITS - p_idx) + 1;
    end
  endtask

  always @(posedge clk) begin
    if (!key[0]) begin
      m_cyc = 0; m_neq = 0; m_gt = 0; m_lt = 0; m_idx = 0;
    end else if (m_cyc == 0) begin
      if (bus.start) begin
        predict(bus.a, bus.b);
        m_cyc = 1; m_neq = 0; m_gt = 0; m_lt = 0; m_idx = 0;
      end
    end else if (m_cyc == m_lat) begin
      m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_cyc == m_lat) begin
        m_neq = p_neq; m_gt = p_gt; m_lt = p_lt; m_idx = p_idx;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.done) n_done++;
      check("busy",     int'(bus.busy),     int'(m_cyc != 0));
      check("done",     int'(bus.done),     int'(m_cyc != 0 && m_cyc == m_lat));
      check("neq",      int'(bus.neq),      int'(m_neq));
      check("a_gt_b",   int'(bus.a_gt_b),   int'(m_gt));
      check("a_lt_b",   int'(bus.a_lt_b),   int'(m_lt));
      check("diff_idx", int'(bus.diff_idx), m_idx);
      check("gt_lt_excl", int'(bus.a_gt_b & bus.a_lt_b), 0);
    end
  end

  // ---------------- directed stimulus ----------------
  int cyc;

  // Returns at the negedge of cycle 1 (start sampled on the edge before).
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input int neq,
                               input int gt, input int lt, input int idx);
    wait_done();
    check({tag, "_done_cycle"}, cyc, lat);
    check({tag, "_neq"},      int'(bus.neq),      neq);
    check({tag, "_gt"},       int'(bus.a_gt_b),   gt);
    check({tag, "_lt"},       int'(bus.a_lt_b),   lt);
    check({tag, "_idx"},      int'(bus.diff_idx), idx);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_done = 0; chk_en = 1'b0;
    key = 4'b1110; bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'hA5;

    // Reset held two cycles with start asserted
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_neq",  int'(bus.neq),  0);
    check("rst_idx",  int'(bus.diff_idx), 0);
    key = 4'b1111; bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    // Equal operands
    launch(8'hB4, 8'hB4);
    check("eq_busy_c1", int'(bus.busy), 1);
    expect_result("eq", 5, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // MSD differs
    launch(8'hC0, 8'h80);
    expect_result("msd", 2, 1, 1, 0, 3);
    repeat (2) @(negedge clk);

    // LSD decides, A < B
    launch(8'h1D, 8'h1E);
    expect_result("lsd", 5, 1, 0, 1, 0);
    repeat (3) @(negedge clk);
    check("hold_lt", int'(bus.a_lt_b), 1);

    // Start re-pulsed and operands changed mid-scan
    n_done = 0;
    launch(8'h1D, 8'h1E);
    @(negedge clk); cyc++;
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    @(negedge clk); cyc++;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'hFF;
    expect_result("ign", 5, 1, 0, 1, 0);
    repeat (5) @(negedge clk);
    check("ign_one_done", n_done, 1);

    // Reset mid-scan then fresh start
    n_done = 0;
    launch(8'hFF, 8'hFE);
    @(negedge clk);
    key = 4'b1110;
    @(negedge clk);
    key = 4'b1111;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_gt",   int'(bus.a_gt_b), 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", n_done, 0);
    launch(8'hFF, 8'hFE);
    expect_result("fresh", 5, 1, 1, 0, 0);
    repeat (2) @(negedge clk);

    // Middle digits and start held high back-to-back
    launch(8'h6C, 8'h7C);
    expect_result("mid", 3, 1, 0, 1, 2);
    launch(8'h39, 8'h35);
    expect_result("mid1", 4, 1, 1, 0, 1);
    @(negedge clk);
    bus.a = 8'h00; bus.b = 8'h03; bus.start = 1'b1;
    repeat (16) @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_end", int'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
